// File: rtl/raytracing_scheduler.sv
// Frame sequencer for the raytracing worker array: per segment it sets up row terms,
// launches workers, waits for completion, then streams colours to the framebuffer.
// Ports: clk/rst, start/sphere_y (frame control), frame_done/error (status),
// worker_activate/worker_busy/pixel_*/doty_r/sphere_y_sqrd/worker_buffer (workers),
// fb_we/fb_addr/fb_data/fb_ready (framebuffer write port).
module raytracing_scheduler #(
  parameter int N_WORKERS        = 4,
  parameter int JOBS_SUBDIVISION = 8,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480,
  parameter int FP_B             = 4,
  parameter int S_B              = 16,
  parameter int TIMEOUT          = 1023
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic signed [S_B-1:0]                  sphere_y,
  output logic                                   frame_done,
  output logic                                   error,
  output logic [N_WORKERS-1:0]                   worker_activate,
  input  logic [N_WORKERS-1:0]                   worker_busy,
  output logic [N_WORKERS*12-1:0]                pixel_start_x,
  output logic signed [11:0]                     pixel_y,
  output logic [16:0]                            pixel_y_sqrd,
  output logic signed [31:0]                     doty_r,
  output logic [31:0]                            sphere_y_sqrd,
  input  logic [N_WORKERS*JOBS_SUBDIVISION*12-1:0] worker_buffer,
  output logic                                   fb_we,
  output logic [18:0]                            fb_addr,
  output logic [11:0]                            fb_data,
  input  logic                                   fb_ready
);

  localparam int SEG  = N_WORKERS * JOBS_SUBDIVISION;
  localparam int NSEG = SCREEN_W / SEG;
  localparam int RW   = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam int SW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int KW   = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int BW   = N_WORKERS * JOBS_SUBDIVISION * 12;

  localparam logic [TW-1:0] TLIM     = TW'(TIMEOUT - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(SEG - 1);
  localparam logic [SW-1:0] SEG_LAST = SW'(NSEG - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LAUNCH, S_RUN, S_RELEASE, S_DRAIN, S_NEXT
  } state_t;

  state_t                 state_q;
  logic [RW-1:0]          row_q;
  logic [SW-1:0]          seg_q;
  logic [KW-1:0]          k_q;
  logic [TW-1:0]          tmr_q;
  logic signed [S_B-1:0]  sy_q;

  logic signed [11:0]     py_d;
  logic signed [16:0]     py17_d;
  logic signed [16:0]     pysq_d;
  logic signed [S_B+11:0] doty_d;
  logic signed [2*S_B-1:0] sysq_d;
  logic [18:0]            base_d;
  logic [N_WORKERS*12-1:0] psx_d;

  assign py_d   = 12'(SCREEN_H / 2 - int'(row_q));
  assign py17_d = 17'(py_d);
  // 17-bit product is exact: |pixel_y| <= 240 keeps the square below 2^17
  assign pysq_d = py17_d * py17_d;
  assign doty_d = py_d * sy_q;
  assign sysq_d = sy_q * sy_q;
  assign base_d = 19'(int'(row_q) * SCREEN_W + int'(seg_q) * SEG);

  always_comb begin
    psx_d = '0;
    for (int i = 0; i < N_WORKERS; i++)
      psx_d[12*i +: 12] = 12'(int'(seg_q) * SEG - SCREEN_W / 2 + i);
  end

  // drain order interleaves workers: k -> worker k%N, job k/N
  function automatic logic [11:0] pick(
    input logic [BW-1:0] wb,
    input logic [KW-1:0] k
  );
    int idx;
    idx = (int'(k) % N_WORKERS) * JOBS_SUBDIVISION + int'(k) / N_WORKERS;
    return wb[idx*12 +: 12];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      seg_q           <= '0;
      k_q             <= '0;
      tmr_q           <= '0;
      sy_q            <= '0;
      frame_done      <= 1'b0;
      error           <= 1'b0;
      worker_activate <= '0;
      pixel_start_x   <= '0;
      pixel_y         <= '0;
      pixel_y_sqrd    <= '0;
      doty_r          <= '0;
      sphere_y_sqrd   <= '0;
      fb_we           <= 1'b0;
      fb_addr         <= '0;
      fb_data         <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sy_q    <= sphere_y;
            error   <= 1'b0;
            row_q   <= '0;
            seg_q   <= '0;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          pixel_y         <= py_d;
          pixel_y_sqrd    <= pysq_d;
          doty_r          <= 32'(doty_d);
          sphere_y_sqrd   <= 32'(sysq_d >>> FP_B);
          pixel_start_x   <= psx_d;
          tmr_q           <= '0;
          worker_activate <= '1;
          state_q         <= S_LAUNCH;
        end
        S_LAUNCH: begin
          if (worker_busy == '1) begin
            tmr_q   <= '0;
            state_q <= S_RUN;
          end else if (tmr_q == TLIM) begin
            error           <= 1'b1;
            worker_activate <= '0;
            state_q         <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_RUN: begin
          if (worker_busy == '0) begin
            worker_activate <= '0;
            state_q         <= S_RELEASE;
          end else if (tmr_q == TLIM) begin
            error           <= 1'b1;
            worker_activate <= '0;
            state_q         <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_RELEASE: begin
          k_q     <= '0;
          fb_we   <= 1'b1;
          fb_addr <= base_d;
          fb_data <= pick(worker_buffer, '0);
          state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (fb_ready) begin
            if (k_q == K_LAST) begin
              fb_we   <= 1'b0;
              state_q <= S_NEXT;
            end else begin
              k_q     <= k_q + 1'b1;
              fb_addr <= fb_addr + 1'b1;
              fb_data <= pick(worker_buffer, KW'(k_q + 1'b1));
            end
          end
        end
        S_NEXT: begin
          if (seg_q != SEG_LAST) begin
            seg_q   <= seg_q + 1'b1;
            state_q <= S_SETUP;
          end else if (row_q != ROW_LAST) begin
            seg_q   <= '0;
            row_q   <= row_q + 1'b1;
            state_q <= S_SETUP;
          end else begin
            frame_done <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raytracing_scheduler.sv
// Self-checking bench for raytracing_scheduler: full-size instance for row terms,
// drain, stall, timeout and reset; a 64x4 instance for a complete frame.
module tb_raytracing_scheduler;

  localparam int RUN_LEN = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [383:0] wbuf;
  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        wbuf[(i*8+j)*12 +: 12] = 12'(i * 16 + j);
  end

  logic               a_start = 0, a_fd, a_err, a_we, a_fbr = 1;
  logic signed [15:0] a_sy = 0;
  logic [3:0]         a_act, a_busy, dead_a = 0;
  logic [47:0]        a_psx;
  logic signed [11:0] a_py;
  logic [16:0]        a_pysq;
  logic signed [31:0] a_doty;
  logic [31:0]        a_sysq;
  logic [18:0]        a_addr;
  logic [11:0]        a_data;

  logic               b_start = 0, b_fd, b_err, b_we;
  logic [3:0]         b_act, b_busy;
  logic [47:0]        b_psx;
  logic signed [11:0] b_py;
  logic [16:0]        b_pysq;
  logic signed [31:0] b_doty;
  logic [31:0]        b_sysq;
  logic [18:0]        b_addr;
  logic [11:0]        b_data;

  raytracing_scheduler dut_a (
    .clk(clk), .rst(rst), .start(a_start), .sphere_y(a_sy),
    .frame_done(a_fd), .error(a_err),
    .worker_activate(a_act), .worker_busy(a_busy),
    .pixel_start_x(a_psx), .pixel_y(a_py), .pixel_y_sqrd(a_pysq),
    .doty_r(a_doty), .sphere_y_sqrd(a_sysq), .worker_buffer(wbuf),
    .fb_we(a_we), .fb_addr(a_addr), .fb_data(a_data), .fb_ready(a_fbr)
  );

  raytracing_scheduler #(.SCREEN_W(64), .SCREEN_H(4)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .sphere_y(16'sh0100),
    .frame_done(b_fd), .error(b_err),
    .worker_activate(b_act), .worker_busy(b_busy),
    .pixel_start_x(b_psx), .pixel_y(b_py), .pixel_y_sqrd(b_pysq),
    .doty_r(b_doty), .sphere_y_sqrd(b_sysq), .worker_buffer(wbuf),
    .fb_we(b_we), .fb_addr(b_addr), .fb_data(b_data), .fb_ready(1'b1)
  );

  // worker models: busy one cycle after activate, low after RUN_LEN cycles
  int   a_cnt = 0, b_cnt = 0;
  logic a_done = 0, b_done = 0;
  initial begin a_busy = 0; b_busy = 0; end

  always @(posedge clk) begin
    if (a_act == 0) begin
      a_busy <= 0; a_cnt <= 0; a_done <= 0;
    end else if (!a_done) begin
      if (a_cnt == RUN_LEN) begin a_busy <= 0; a_done <= 1; end
      else begin a_busy <= ~dead_a; a_cnt <= a_cnt + 1; end
    end
  end

  always @(posedge clk) begin
    if (b_act == 0) begin
      b_busy <= 0; b_cnt <= 0; b_done <= 0;
    end else if (!b_done) begin
      if (b_cnt == RUN_LEN) begin b_busy <= 0; b_done <= 1; end
      else begin b_busy <= 4'hF; b_cnt <= b_cnt + 1; end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic start_a(input logic signed [15:0] s);
    a_sy = s; a_start = 1;
    @(negedge clk);
    a_start = 0;
  endtask

  typedef struct {
    logic signed [15:0] sy;
    longint py, pysq, doty, sysq, psx0;
  } vec_t;
  vec_t vt[4];

  int n, fall_c, first_c, cnt, done_cnt;
  logic stalled, found;
  logic [3:0] prev_act;
  logic [11:0] hold;

  initial begin
    vt[0] = '{16'sh0100, 240, 57600, 61440, 4096, -320};
    vt[1] = '{-16'sh0040, 240, 57600, -15360, 256, -320};
    vt[2] = '{16'sh7FFF, 240, 57600, 7864080, 67104768, -320};
    vt[3] = '{16'sh8000, 240, 57600, -7864320, 67108864, -320};

    // reset state
    do_reset();
    chk("rst_act", a_act, 0);
    chk("rst_we", a_we, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_data", a_data, 0);
    chk("rst_err", a_err, 0);
    chk("rst_done", a_fd, 0);
    chk("rst_py", a_py, 0);
    chk("rst_psx", a_psx, 0);
    chk("rst_b_we", b_we, 0);

    // row terms
    for (int v = 0; v < 4; v++) begin
      do_reset();
      start_a(vt[v].sy);
      for (int c = 0; c < 10 && a_act == 0; c++) @(negedge clk);
      chk("setup_act", a_act, 15);
      chk("setup_py", a_py, vt[v].py);
      chk("setup_pysq", a_pysq, vt[v].pysq);
      chk("setup_doty", a_doty, vt[v].doty);
      chk("setup_sysq", a_sysq, vt[v].sysq);
      for (int i = 0; i < 4; i++)
        chk("setup_psx", $signed(a_psx[12*i +: 12]), vt[v].psx0 + i);
    end

    // drain order, activate timing, fb_ready stall at k=7
    do_reset();
    start_a(16'sh0100);
    n = 0; stalled = 0; fall_c = -1; first_c = -100; prev_act = 0;
    for (int c = 0; c < 400 && n < 32; c++) begin
      @(negedge clk);
      if (prev_act != 0 && a_act == 0 && fall_c < 0) fall_c = c;
      prev_act = a_act;
      if (a_we && first_c < 0) first_c = c;
      if (a_we && a_addr == 7 && !stalled) begin
        stalled = 1; a_fbr = 0; hold = a_data;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_we", a_we, 1);
          chk("stall_addr", a_addr, 7);
          chk("stall_data", a_data, hold);
        end
        a_fbr = 1;
      end
      if (a_we && a_fbr) begin
        chk("drain_addr", a_addr, n);
        chk("drain_data", a_data, ((n % 4) << 4) | (n / 4));
        n++;
      end
    end
    chk("drain_count", n, 32);
    chk("stall_seen", stalled, 1);
    chk("act_to_we", first_c - fall_c, 1);
    @(negedge clk);
    chk("we_after_last", a_we, 0);

    // timeout: worker 2 never busy
    dead_a = 4'b0100;
    do_reset();
    start_a(16'sh0100);
    cnt = 0;
    for (int c = 0; c < 1200 && !a_err; c++) begin
      @(negedge clk);
      if (a_act != 0) cnt++;
    end
    chk("to_err", a_err, 1);
    chk("to_act", a_act, 0);
    chk("to_cycles", cnt, 1023);
    chk("to_done", a_fd, 0);
    start_a(16'sh0100);
    chk("to_err_clear", a_err, 0);
    dead_a = 0;

    // reset mid-drain at k=10
    do_reset();
    start_a(16'sh0100);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (a_we && a_addr == 10) found = 1;
    end
    chk("k10_reached", found, 1);
    rst = 1;
    @(negedge clk);
    chk("mid_rst_we", a_we, 0);
    chk("mid_rst_addr", a_addr, 0);
    chk("mid_rst_data", a_data, 0);
    chk("mid_rst_act", a_act, 0);
    chk("mid_rst_py", a_py, 0);
    rst = 0;
    @(negedge clk);
    start_a(16'sh0100);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (a_we) found = 1;
    end
    chk("restart_we", found, 1);
    chk("restart_addr", a_addr, 0);

    // full 64x4 frame
    do_reset();
    b_start = 1;
    @(negedge clk);
    b_start = 0;
    n = 0; done_cnt = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      b_start = (c == 100);
      if (b_we) begin
        chk("frame_addr", b_addr, n);
        if (n == 64) begin
          chk("row1_psx0", $signed(b_psx[11:0]), -32);
          chk("row1_py", b_py, 1);
        end
        n++;
      end
      if (b_fd) begin
        done_cnt++;
        chk("done_after_last", n, 256);
      end
    end
    chk("frame_writes", n, 256);
    chk("frame_done_cnt", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
